// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end: deserialises 10-bit command frames for the memory and serialises read bytes onto MISO.
// Optional protocol checking (proto_err output) is enabled by defining SPI_SLAVE_CTRL_PROTO_CHECK_EN.
module spi_slave_ctrl #(
  parameter int WORD_SIZE = 8,
  localparam int CTRL_WIDTH = 2,
  localparam int FRAME_WIDTH = WORD_SIZE + CTRL_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ss_n,
  input  logic                   mosi,
  output logic                   miso,
  output logic [FRAME_WIDTH-1:0] rx_data,
  output logic                   rx_valid,
  input  logic [WORD_SIZE-1:0]   tx_data,
  input  logic                   tx_valid,
  output logic                   busy,
  output logic [2:0]             state_dbg,
  output logic                   rd_addr_done_dbg
`ifdef SPI_SLAVE_CTRL_PROTO_CHECK_EN
  ,
  output logic                   proto_err
`endif
);

  // Handshakes: rx_valid is a one-cycle strobe with no back-pressure, so the memory
  // must take rx_data whenever it is high; tx_valid is only honoured in READ_WAIT.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CHK_CMD    = 3'd1,
    WRITE      = 3'd2,
    READ_ADD   = 3'd3,
    READ_DATA  = 3'd4,
    READ_WAIT  = 3'd5,
    READ_SHIFT = 3'd6,
    DONE       = 3'd7
  } state_t;

  localparam int CNT_W = $clog2(FRAME_WIDTH);
  localparam logic [CNT_W-1:0] LAST_RX = CNT_W'(FRAME_WIDTH - 2);
  localparam logic [CNT_W-1:0] LAST_TX = CNT_W'(WORD_SIZE - 2);
  localparam logic [CTRL_WIDTH-1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [CTRL_WIDTH-1:0] CMD_RD_DATA = 2'b11;

  state_t                   state, state_n;
  logic [FRAME_WIDTH-2:0]   sh, sh_n;
  logic [WORD_SIZE-2:0]     tx_sh, tx_sh_n;
  logic [CNT_W-1:0]         cnt, cnt_n;
  logic                     miso_n;
  logic [FRAME_WIDTH-1:0]   rx_data_n;
  logic                     rx_valid_n;
  logic                     rd_addr_done, rd_n;
  logic [FRAME_WIDTH-1:0]   word;
  logic [CTRL_WIDTH-1:0]    cmd;
  logic                     mismatch;
`ifdef SPI_SLAVE_CTRL_PROTO_CHECK_EN
  logic                     perr_n;
`endif

  assign word = {sh, mosi};
  assign cmd  = word[FRAME_WIDTH-1 -: CTRL_WIDTH];

`ifdef SPI_SLAVE_CTRL_PROTO_CHECK_EN
  assign mismatch = ((state == READ_ADD)  && (cmd == CMD_RD_DATA)) ||
                    ((state == READ_DATA) && (cmd == CMD_RD_ADDR));
`else
  assign mismatch = 1'b0;
`endif

  assign busy             = (state != IDLE);
  assign state_dbg        = state;
  assign rd_addr_done_dbg = rd_addr_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      sh           <= '0;
      tx_sh        <= '0;
      cnt          <= '0;
      miso         <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rd_addr_done <= 1'b0;
`ifdef SPI_SLAVE_CTRL_PROTO_CHECK_EN
      proto_err    <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      sh           <= sh_n;
      tx_sh        <= tx_sh_n;
      cnt          <= cnt_n;
      miso         <= miso_n;
      rx_data      <= rx_data_n;
      rx_valid     <= rx_valid_n;
      rd_addr_done <= rd_n;
`ifdef SPI_SLAVE_CTRL_PROTO_CHECK_EN
      proto_err    <= perr_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    sh_n       = sh;
    tx_sh_n    = tx_sh;
    cnt_n      = cnt;
    miso_n     = miso;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    rd_n       = rd_addr_done;
`ifdef SPI_SLAVE_CTRL_PROTO_CHECK_EN
    perr_n     = 1'b0;
`endif
    // Deselect wins over everything, including the edge that samples bit 0.
    if ((state != IDLE) && ss_n) begin
      state_n = IDLE;
      miso_n  = 1'b0;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (!ss_n) state_n = CHK_CMD;
        end
        CHK_CMD: begin
          sh_n  = {sh[FRAME_WIDTH-3:0], mosi};
          cnt_n = '0;
          if (!mosi)             state_n = WRITE;
          else if (rd_addr_done) state_n = READ_DATA;
          else                   state_n = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          sh_n  = {sh[FRAME_WIDTH-3:0], mosi};
          cnt_n = cnt + 1'b1;
          if (cnt == LAST_RX) begin
            cnt_n = '0;
            if (mismatch) begin
              state_n = DONE;
`ifdef SPI_SLAVE_CTRL_PROTO_CHECK_EN
              perr_n  = 1'b1;
`endif
            end else begin
              rx_data_n  = word;
              rx_valid_n = 1'b1;
              if (cmd == CMD_RD_ADDR)      rd_n = 1'b1;
              else if (cmd == CMD_RD_DATA) rd_n = 1'b0;
              state_n = (state == READ_DATA) ? READ_WAIT : DONE;
            end
          end
        end
        READ_WAIT: begin
          if (tx_valid) begin
            miso_n  = tx_data[WORD_SIZE-1];
            tx_sh_n = tx_data[WORD_SIZE-2:0];
            cnt_n   = '0;
            state_n = READ_SHIFT;
          end
        end
        READ_SHIFT: begin
          miso_n  = tx_sh[WORD_SIZE-2];
          tx_sh_n = {tx_sh[WORD_SIZE-3:0], 1'b0};
          cnt_n   = cnt + 1'b1;
          if (cnt == LAST_TX) begin
            cnt_n   = '0;
            state_n = DONE;
          end
        end
        DONE: begin
          miso_n = 1'b0;
        end
        default: begin
          state_n = IDLE;
          miso_n  = 1'b0;
          cnt_n   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: write, read-address/read-data, abort, reset and protocol-error frames.
module tb_spi_slave_ctrl;

  localparam logic [31:0] S_IDLE = 0, S_CHK = 1, S_RADD = 3, S_RDAT = 4,
                          S_RWAIT = 5, S_RSHIFT = 6, S_DONE = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ss_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       busy;
  logic [2:0] state_dbg;
  logic       rd_addr_done_dbg;
`ifdef SPI_SLAVE_CTRL_PROTO_CHECK_EN
  logic       proto_err;
`endif

  spi_slave_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ss_n             (ss_n),
    .mosi             (mosi),
    .miso             (miso),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .busy             (busy),
    .state_dbg        (state_dbg),
    .rd_addr_done_dbg (rd_addr_done_dbg)
`ifdef SPI_SLAVE_CTRL_PROTO_CHECK_EN
    ,
    .proto_err        (proto_err)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int rxv_cnt = 0;
  int miso_hi_cnt = 0;
  int perr_cnt = 0;

  always @(negedge clk) begin
    if (rx_valid) rxv_cnt++;
    if (miso) miso_hi_cnt++;
`ifdef SPI_SLAVE_CTRL_PROTO_CHECK_EN
    if (proto_err) perr_cnt++;
`endif
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    ss_n = 1'b0;
    tick();
  endtask

  task automatic end_frame();
    ss_n = 1'b1;
    tick();
  endtask

  task automatic send_bits(input logic [9:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      mosi = w[i];
      tick();
    end
  endtask

  int         rxv0;
  int         mh0;
  int         pe0;
  logic [7:0] exp_byte;

  initial begin
    // reset
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_miso", miso, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, S_IDLE);
    check("rst_rd_done", rd_addr_done_dbg, 0);
    rst_n = 1'b1;
    tick();

    // write address 00_0010_1010
    rxv0 = rxv_cnt;
    mh0  = miso_hi_cnt;
    start_frame();
    check("wa_busy", busy, 1);
    check("wa_chk", state_dbg, S_CHK);
    send_bits(10'h02A, 9, 0);
    check("wa_valid", rx_valid, 1);
    check("wa_data", rx_data, 10'h02A);
    check("wa_state", state_dbg, S_DONE);
    mosi = 1'b1;
    tx_valid = 1'b1;
    tx_data = 8'hFF;
    tick();
    tx_valid = 1'b0;
    check("wa_valid_drop", rx_valid, 0);
    tick();
    tick();
    check("wa_pulses", rxv_cnt - rxv0, 1);
    check("wa_busy_done", busy, 1);
    end_frame();
    check("wa_idle", state_dbg, S_IDLE);
    check("wa_busy_idle", busy, 0);
    check("wa_miso_quiet", miso_hi_cnt - mh0, 0);

    // write data 01_1010_0101
    rxv0 = rxv_cnt;
    start_frame();
    send_bits(10'h1A5, 9, 0);
    check("wd_valid", rx_valid, 1);
    check("wd_data", rx_data, 10'h1A5);
    tick();
    check("wd_pulses", rxv_cnt - rxv0, 1);
    check("wd_rd_done", rd_addr_done_dbg, 0);
    end_frame();
    check("wd_idle", state_dbg, S_IDLE);

    // read address then read data
    start_frame();
    send_bits(10'h22A, 9, 0);
    check("ra_data", rx_data, 10'h22A);
    check("ra_state", state_dbg, S_DONE);
    check("ra_rd_done", rd_addr_done_dbg, 1);
    end_frame();
    check("ra_rd_kept", rd_addr_done_dbg, 1);
    rxv0 = rxv_cnt;
    start_frame();
    send_bits(10'h300, 9, 9);
    check("rd_enter", state_dbg, S_RDAT);
    send_bits(10'h300, 8, 0);
    check("rd_valid", rx_valid, 1);
    check("rd_data", rx_data, 10'h300);
    check("rd_wait", state_dbg, S_RWAIT);
    check("rd_rd_clr", rd_addr_done_dbg, 0);
    exp_byte = 8'hA5;
    tx_data  = exp_byte;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    check("rd_shift", state_dbg, S_RSHIFT);
    check("rd_miso7", miso, exp_byte[7]);
    for (int i = 6; i >= 0; i--) begin
      tick();
      check($sformatf("rd_miso%0d", i), miso, exp_byte[i]);
    end
    tick();
    check("rd_miso_end", miso, 0);
    check("rd_done", state_dbg, S_DONE);
    check("rd_pulses", rxv_cnt - rxv0, 1);
    end_frame();

    // abort after 5 bits, then abort on the bit-0 edge
    rxv0 = rxv_cnt;
    start_frame();
    send_bits(10'h0AA, 9, 5);
    ss_n = 1'b1;
    tick();
    check("ab5_idle", state_dbg, S_IDLE);
    start_frame();
    send_bits(10'h0AA, 9, 1);
    ss_n = 1'b1;
    mosi = 1'b0;
    tick();
    check("ab0_idle", state_dbg, S_IDLE);
    tick();
    check("ab_pulses", rxv_cnt - rxv0, 0);
    check("ab_hold", rx_data, 10'h300);
    start_frame();
    send_bits(10'h0FF, 9, 0);
    check("ab_next_data", rx_data, 10'h0FF);
    check("ab_next_valid", rx_valid, 1);
    end_frame();

    // reset during READ_SHIFT
    start_frame();
    send_bits(10'h22A, 9, 0);
    end_frame();
    start_frame();
    send_bits(10'h300, 9, 0);
    exp_byte = 8'h5A;
    tx_data  = exp_byte;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    tick();
    tick();
    check("rs_miso_pre", miso, exp_byte[4]);
    rst_n = 1'b0;
    tick();
    check("rs_miso", miso, 0);
    check("rs_busy", busy, 0);
    check("rs_rd_done", rd_addr_done_dbg, 0);
    rst_n = 1'b1;
    ss_n  = 1'b1;
    tick();

    // reset while rd_addr_done is set, then bit9=1 must pick READ_ADD
    start_frame();
    send_bits(10'h2AA, 9, 0);
    check("rs2_rd_set", rd_addr_done_dbg, 1);
    rst_n = 1'b0;
    tick();
    check("rs2_rd_clr", rd_addr_done_dbg, 0);
    check("rs2_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    check("rs2_chk", state_dbg, S_CHK);
    send_bits(10'h3FF, 9, 9);
    check("rs2_radd", state_dbg, S_RADD);
    end_frame();

    // read-data command while no read address is pending
    rxv0 = rxv_cnt;
    mh0  = miso_hi_cnt;
    pe0  = perr_cnt;
    start_frame();
    send_bits(10'h300, 9, 0);
`ifdef SPI_SLAVE_CTRL_PROTO_CHECK_EN
    check("pe_pulse", proto_err, 1);
    check("pe_no_valid", rx_valid, 0);
    check("pe_state", state_dbg, S_DONE);
    tick();
    check("pe_drop", proto_err, 0);
    tick();
    check("pe_count", perr_cnt - pe0, 1);
    check("pe_pulses", rxv_cnt - rxv0, 0);
    check("pe_rd_done", rd_addr_done_dbg, 0);
    check("pe_miso", miso_hi_cnt - mh0, 0);
    end_frame();
    // read-address command while a read address is already pending
    start_frame();
    send_bits(10'h2AA, 9, 0);
    end_frame();
    rxv0 = rxv_cnt;
    start_frame();
    send_bits(10'h211, 9, 0);
    check("pe2_pulse", proto_err, 1);
    check("pe2_state", state_dbg, S_DONE);
    check("pe2_rd_kept", rd_addr_done_dbg, 1);
    tick();
    check("pe2_pulses", rxv_cnt - rxv0, 0);
    end_frame();
`else
    check("np_valid", rx_valid, 1);
    check("np_data", rx_data, 10'h300);
    check("np_state", state_dbg, S_DONE);
    check("np_rd_done", rd_addr_done_dbg, 0);
    tick();
    tick();
    check("np_pulses", rxv_cnt - rxv0, 1);
    check("np_miso", miso_hi_cnt - mh0, 0);
    end_frame();
`endif

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
